// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Multi-cycle adder/subtractor that processes one 4-bit nibble per clock with a
// single shared 4-bit carry-lookahead slice. An accepted request runs for
// N = WIDTH/4 cycles with busy high. It then spends one cycle in DONE with done
// high, while sum/cout/overflow present the new result.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset
//   start     - operation request, only looked at while idle
//   a, b      - WIDTH-bit operands
//   cin       - carry-in for addition (ignored for subtraction)
//   sub       - 1: a - b, 0: a + b + cin
//   busy      - high while nibble steps are running
//   done      - one-cycle pulse when a new result is presented
//   sum       - registered result, only updated when an operation completes
//   cout      - carry out of the MSB (for subtraction: 1 = no borrow)
//   overflow  - signed two's-complement overflow of the completed operation
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, work_reg, sum_reg;
    logic [WIDTH-1:0] work_next;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg, cout_reg, overflow_reg;

    // Nibble views of the latched operands so the slice can pick one by idx.
    logic [3:0] a_nib [N];
    logic [3:0] b_nib [N];

    // Shared 4-bit carry-lookahead slice.
    logic [3:0] nib_a, nib_b, p, g, slice_sum;
    logic [4:0] c;
    logic       last_step;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
            // Only the nibble addressed this step takes the slice result;
            // every other nibble of the working register holds.
            assign work_next[4*gi +: 4] =
                (state_reg == RUN && idx_reg == IDX_W'(gi)) ? slice_sum
                                                            : work_reg[4*gi +: 4];
        end
    endgenerate

    assign nib_a = a_nib[idx_reg];
    assign nib_b = b_nib[idx_reg];
    assign p     = nib_a ^ nib_b;
    assign g     = nib_a & nib_b;

    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign slice_sum = p ^ c[3:0];
    assign last_step = (idx_reg == IDX_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            work_reg     <= '0;
            sum_reg      <= '0;
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and force carry-in.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    work_reg  <= work_next;
                    carry_reg <= c[4];
                    if (last_step) begin
                        // work_next already holds the final nibble.
                        sum_reg      <= work_next;
                        cout_reg     <= c[4];
                        overflow_reg <= c[3] ^ c[4];
                        idx_reg      <= '0;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: idx_reg <= '0;
            endcase
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_serial_adder_ctrl (WIDTH=16). Expected results are
// computed from full-width arithmetic and queued when a request is issued, then
// popped and compared when done is seen.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] sum;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        exp_t         e;
        logic [WIDTH:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   r = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        e.a    = x;
        e.b    = y;
        e.sub  = s;
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
        if (s) e.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        else   e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Drive a request for one cycle (called at posedge+1 while idle) and queue
    // the expected result. Operands are scrambled afterwards.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic s, input bit expect_result);
        start = 1'b1; a = x; b = y; cin = ci; sub = s;
        if (expect_result) sb.push_back(model(x, y, ci, s));
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
    endtask

    // Wait (bounded) for done, counting busy cycles seen before it.
    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, overflow} !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     busy, done, sum, cout, overflow);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_add_sub;
        logic [WIDTH-1:0] va [10];
        logic [WIDTH-1:0] vb [10];
        logic             vc [10];
        logic             vs [10];
        int   nbusy;
        bit   seen;
        exp_t e;
        va = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000};
        vb = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0007, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000};
        vc = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0};
        vs = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0};
        for (int t = 0; t < 14; t++) begin
            if (t < 10) issue(va[t], vb[t], vc[t], vs[t], 1'b1);
            else        issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            wait_done(nbusy, seen);
            checks++;
            if (!seen || nbusy != N) begin
                errors++;
                $display("FAIL latency[%0d]: got done_seen=%b busy_cycles=%0d, expected 1 and %0d", t, seen, nbusy, N);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty[%0d]: got empty queue, expected an entry", t);
            end else begin
                e = sb.pop_front();
                checks++;
                if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL result[%0d]: a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b busy=%b, expected sum=%h cout=%b ovf=%b busy=0",
                             t, e.a, e.b, e.sub, sum, cout, overflow, busy, e.sum, e.cout, e.ovf);
                end
                $display("op a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.sub, sum, cout, overflow);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_width[%0d]: got done=%b busy=%b after DONE, expected 0 0", t, done, busy);
            end
        end
    endtask

    task automatic test_ignore_start;
        int   nbusy, pulses;
        bit   seen;
        exp_t e;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; a = 16'hABCD; b = 16'h0F0F; sub = 1'b1;   // RUN cycle 2
        @(posedge clk); #1;                                      // RUN cycle 3
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(nbusy, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ignore_start_done: got no done, expected done");
        end
        e = sb.pop_front();
        checks++;
        if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL ignore_start_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
        $display("op a=%h b=%h sub=%b (start pulsed in RUN) -> sum=%h", e.a, e.b, e.sub, sum);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL ignore_start_extra: got %0d extra busy/done cycles, expected 0", pulses);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int   nbusy;
        bit   seen;
        exp_t e;
        logic [WIDTH-1:0] prev;
        prev = sum;
        issue(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 1'b1);
        wait_done(nbusy, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || sum !== e.sum || cout !== e.cout) begin
            errors++;
            $display("FAIL b2b_first: got seen=%b sum=%h cout=%b, expected sum=%h cout=%b", seen, sum, cout, e.sum, e.cout);
        end
        $display("op a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.sub, sum, cout, overflow);
        prev = sum;
        @(posedge clk); #1;
        issue(16'h0F00, 16'h00F1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (sum !== prev || busy !== 1'b1) begin
            errors++;
            $display("FAIL sum_stable_in_run: got sum=%h busy=%b, expected sum=%h busy=1", sum, busy, prev);
        end
        wait_done(nbusy, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || nbusy != N - 1 || sum !== e.sum || cout !== e.cout || overflow !== e.ovf) begin
            errors++;
            $display("FAIL b2b_second: got seen=%b busy=%0d sum=%h cout=%b ovf=%b, expected busy=%0d sum=%h cout=%b ovf=%b",
                     seen, nbusy, sum, cout, overflow, N - 1, e.sum, e.cout, e.ovf);
        end
        $display("op a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.sub, sum, cout, overflow);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        int   nbusy, pulses;
        bit   seen;
        exp_t e;
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        wait_done(nbusy, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || sum !== 16'h5555) begin
            errors++;
            $display("FAIL pre_reset_result: got seen=%b sum=%h, expected sum=5555", seen, sum);
        end
        @(posedge clk); #1;
        issue(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0);   // aborted, nothing queued
        @(posedge clk); #1;                           // RUN cycle 2
        @(posedge clk); #1;                           // RUN cycle 3
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected 0 0 0000 0 0",
                     busy, done, sum, cout, overflow);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses, expected 0", pulses);
        end
        $display("reset during RUN -> sum=%h", sum);
        @(posedge clk); #1;
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        wait_done(nbusy, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || nbusy != N || sum !== e.sum || overflow !== e.ovf) begin
            errors++;
            $display("FAIL after_reset_op: got seen=%b busy=%0d sum=%h ovf=%b, expected busy=%0d sum=%h ovf=%b",
                     seen, nbusy, sum, overflow, N, e.sum, e.ovf);
        end
        $display("op a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.sub, sum, cout, overflow);
        @(posedge clk); #1;
    endtask

    task automatic test_start_after_reset;
        int   nbusy;
        bit   seen;
        exp_t e;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_done(nbusy, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || nbusy != N || sum !== 16'h0100 || cout !== 1'b0) begin
            errors++;
            $display("FAIL start_after_reset: got seen=%b busy=%0d sum=%h cout=%b, expected busy=%0d sum=0100 cout=0",
                     seen, nbusy, sum, cout, N);
        end
        $display("op a=%h b=%h sub=%b (first cycle after reset) -> sum=%h", e.a, e.b, e.sub, sum);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_start_after_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
